// File: rtl/led_status_array.sv
// Per-channel self-test result indicator: off until done, steady on for pass,
// and a blink or blink-code pattern for fail. All outputs are registered.
module led_status_array #(
    parameter int CH_NUM      = 4,
    parameter int HALF_PERIOD = 25_000_000,
    parameter int CNT_W       = 25,
    parameter int CODE_W      = 3,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [CH_NUM-1:0]          done,
    input  logic [CH_NUM-1:0]          result,
    input  logic [CH_NUM*CODE_W-1:0]   err_code,
    output logic [CH_NUM-1:0]          led,
    output logic                       all_pass,
    output logic                       any_fail
);

    // state   | meaning
    // ST_IDLE | waiting for done, LED off
    // ST_PASS | test passed, LED steady on
    // ST_FAIL | test failed, LED shows blink / blink-code pattern
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam int S_MAX = 2 * ((1 << CODE_W) - 1) + PAUSE_TICKS;
    localparam int S_W   = $clog2(S_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CH_NUM-1:0] w_led_n;
    logic [CH_NUM-1:0] w_pass_n;
    logic [CH_NUM-1:0] w_fail_n;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        state_t            r_state, w_state_n;
        logic [CNT_W-1:0]  r_cnt, w_cnt_n;
        logic [S_W-1:0]    r_step, w_step_n;
        logic [S_W-1:0]    w_len;
        logic [S_W-1:0]    w_two_c_n;
        logic [CODE_W-1:0] r_code, w_code_n;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_step  <= '0;
                r_code  <= '0;
            end else begin
                r_state <= w_state_n;
                r_cnt   <= w_cnt_n;
                r_step  <= w_step_n;
                r_code  <= w_code_n;
            end
        end

        always_comb begin
            w_state_n = r_state;
            w_cnt_n   = r_cnt;
            w_step_n  = r_step;
            w_code_n  = r_code;
            // Steps in one burst: plain blink uses two, code N uses N pulses plus the pause
            w_len     = (r_code == '0) ? S_W'(2)
                                       : S_W'({r_code, 1'b0}) + S_W'(PAUSE_TICKS);
            if (clear) begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
                w_step_n  = '0;
                w_code_n  = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (done[g]) begin
                            if (result[g]) begin
                                w_state_n = ST_PASS;
                            end else begin
                                w_state_n = ST_FAIL;
                                w_code_n  = err_code[g*CODE_W +: CODE_W];
                                w_cnt_n   = '0;
                                w_step_n  = '0;
                            end
                        end
                    end
                    ST_PASS: begin
                        w_state_n = ST_PASS;
                    end
                    ST_FAIL: begin
                        if (r_cnt == CNT_LAST) begin
                            w_cnt_n  = '0;
                            w_step_n = (r_step == w_len - S_W'(1)) ? '0 : r_step + S_W'(1);
                        end else begin
                            w_cnt_n  = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_n = ST_IDLE;
                    end
                endcase
            end
            w_two_c_n = S_W'({w_code_n, 1'b0});
        end

        // LED is registered from the next-state values so it follows done by one cycle
        assign w_led_n[g]  = (w_state_n == ST_PASS) |
                             ((w_state_n == ST_FAIL) & ~w_step_n[0] &
                              ((w_code_n == '0) | (w_step_n < w_two_c_n)));
        assign w_pass_n[g] = (w_state_n == ST_PASS);
        assign w_fail_n[g] = (w_state_n == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led      <= '0;
            all_pass <= 1'b0;
            any_fail <= 1'b0;
        end else begin
            led      <= w_led_n;
            all_pass <= &w_pass_n;
            any_fail <= |w_fail_n;
        end
    end

endmodule

// File: tb/tb_led_status_array.sv
// Scoreboard bench for led_status_array: stimulus pushes per-cycle expectations,
// a monitor pops and compares them one cycle later.
module tb_led_status_array;

    localparam int CH  = 4;
    localparam int CW  = 3;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [CH-1:0]    done;
    logic [CH-1:0]    result;
    logic [CH*CW-1:0] err_code;
    logic [CH-1:0]    led;
    logic             all_pass;
    logic             any_fail;

    led_status_array #(
        .CH_NUM(CH), .HALF_PERIOD(4), .CNT_W(3), .CODE_W(CW), .PAUSE_TICKS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .done(done), .result(result),
        .err_code(err_code), .led(led), .all_pass(all_pass), .any_fail(any_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] led;
        logic     ap;
        logic     af;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int m_st[CH];     // 0 idle, 1 pass, 2 fail
    int m_code[CH];
    int m_start[CH];

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-written LED sequences for HALF_PERIOD=4, PAUSE_TICKS=3, first bit at t=0
    function automatic logic exp_fail_led(input int code, input int t);
        logic [7:0]  p0 = 8'b1111_0000;
        logic [19:0] p1 = 20'b1111_0000_0000_0000_0000;
        logic [27:0] p2 = 28'b1111_0000_1111_0000_0000_0000_0000;
        case (code)
            0:       return p0[7 - (t % 8)];
            1:       return p1[19 - (t % 20)];
            2:       return p2[27 - (t % 28)];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_st[i] = 0; m_code[i] = 0; m_start[i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] d, input logic [3:0] r,
                        input logic [11:0] e, input logic clr);
        exp_t x;
        done = d; result = r; err_code = e; clear = clr;
        if (clr) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (d[i] && m_st[i] == 0) begin
                    m_st[i]    = r[i] ? 1 : 2;
                    m_code[i]  = int'(e[i*CW +: CW]);
                    m_start[i] = cyc + 1;
                end
            end
        end
        x.cyc = cyc + 1;
        x.ap  = 1'b1;
        x.af  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            x.led[i] = (m_st[i] == 1) ? 1'b1 :
                       (m_st[i] == 2) ? exp_fail_led(m_code[i], cyc + 1 - m_start[i]) : 1'b0;
            if (m_st[i] != 1) x.ap = 1'b0;
            if (m_st[i] == 2) x.af = 1'b1;
        end
        q.push_back(x);
        @(posedge clk);
        #1;
        done = '0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, 4'b0000, 12'h000, 1'b0);
    endtask

    task automatic chk_zero(input string name);
        n_tests++;
        if (led !== 4'b0000 || all_pass !== 1'b0 || any_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: led got %b exp 0000, all_pass got %b exp 0, any_fail got %b exp 0",
                     name, led, all_pass, any_fail);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL stale_expectation: cycle %0d never checked (now %0d)", e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_tests++;
            if (led !== e.led || all_pass !== e.ap || any_fail !== e.af) begin
                n_fail++;
                $display("FAIL cycle_%0d: led got %b exp %b, all_pass got %b exp %b, any_fail got %b exp %b",
                         cyc, led, e.led, all_pass, e.ap, any_fail, e.af);
            end
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0; clear = 1'b0; done = '0; result = '0; err_code = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst_n = 1'b1;

        // Idle, then ch0 pass; a later fail on ch0 is ignored
        idle(50);
        step(4'b0001, 4'b0001, 12'h000, 1'b0);
        idle(10);
        step(4'b0001, 4'b0000, 12'h005, 1'b0);
        idle(5);

        // ch1 fail code 0; a later pass on ch1 is ignored
        step(4'b0010, 4'b0000, 12'h000, 1'b0);
        idle(20);
        step(4'b0010, 4'b0010, 12'h000, 1'b0);
        idle(5);

        // ch2 fail code 2
        step(4'b0100, 4'b0000, 12'h080, 1'b0);
        idle(60);

        // clear, all pass together, then clear beats a simultaneous ch3 done
        step(4'b0000, 4'b0000, 12'h000, 1'b1);
        idle(2);
        step(4'b1111, 4'b1111, 12'h000, 1'b0);
        idle(3);
        step(4'b1000, 4'b1000, 12'h000, 1'b1);
        idle(5);

        // ch2 code 2 again, async reset while led[2] is in its second on-phase
        step(4'b0100, 4'b0000, 12'h080, 1'b0);
        idle(9);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset_mid_blink");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_held");
        rst_n = 1'b1;

        // Simultaneous: ch0 pass, ch1 code 0, ch2 code 1, ch3 code 2
        step(4'b1111, 4'b0001, 12'h440, 1'b0);
        idle(45);

        #5;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
